mult_sequencer: RTL
===================

# mult_sequencer

Multi-cycle controller and datapath for the ALU multiply operation (ALU control code MULT_OP = 4'd8). It accepts a multiply request from the EX stage, runs a radix-2 shift-add multiplication over WIDTH cycles, and stalls the pipeline meanwhile. It delivers a 2·WIDTH-bit product into HI/LO registers. It sits beside the single-cycle ALU in EX and is started by the EX-stage decode when alu_control equals MULT_OP.

## Interface
Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- arst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- signed_mode  in  1  1 = signed (mult), 0 = unsigned (multu); sampled with start.
- operand_a  in  WIDTH  multiplicand; sampled with start.
- operand_b  in  WIDTH  multiplier; sampled with start.
- flush  in  1  synchronous abort from hazard unit.
- busy  out  1  high in RUN and FIX.
- stall  out  1  pipeline hold request.
- done  out  1  one-cycle pulse; HI/LO updated in the same cycle.
- hi  out  WIDTH  upper product half, registered.
- lo  out  WIDTH  lower product half, registered.

Clocking and reset: one clock, clk; reset is asynchronous and active-low, arst_n.

## Operation
- States: IDLE, RUN, FIX, DONE. Reset state is IDLE.
- IDLE: when start=1 and flush=0, the block latches |a| and |b| (two's-complement magnitude if signed_mode, else raw), stores the result sign (a[MSB] XOR b[MSB] AND signed_mode), clears the 2·WIDTH accumulator and count, and goes to RUN.
- RUN: each cycle, if multiplier LSB=1, add the multiplicand shifted left by count into the accumulator (2·WIDTH-bit add, no overflow possible); then shift the multiplier right and increment count. After WIDTH iterations (count = WIDTH−1 processed), go to FIX.
- FIX: if the sign bit is set, negate the accumulator (2·WIDTH two's complement). Go to DONE.
- DONE: hi/lo ← accumulator, done=1; go to IDLE unconditionally.
- The magnitude of 0x80..0 is 0x80..0 treated as unsigned; no special case.
- start in RUN, FIX or DONE is ignored; it is not queued.
- flush in RUN or FIX returns the block to IDLE next cycle; no done, and hi/lo keep their old values. flush in DONE has no effect (the result is committed). flush with start in IDLE means no start.
- hi/lo hold their value until the next DONE.

## Timing
- Reset values: state=IDLE, busy=0, stall=0, done=0, hi=0, lo=0, accumulator/count=0. Reset is effective immediately, including mid-operation.
- stall = (IDLE & start & ~flush) | RUN | FIX. This is combinational from state and inputs; it is low in DONE so EX advances and consumes hi/lo.
- busy and done are decoded from registered state.
- Latency: start accepted at edge 0; RUN occupies cycles 1..WIDTH; FIX at cycle WIDTH+1; DONE (done=1, hi/lo valid) at cycle WIDTH+2. Back-to-back: the next start is accepted in the IDLE cycle after DONE. Throughput is one multiply per WIDTH+3 cycles.

## Structure
- Shared package alu_pkg: ALU control code constants (AND_OP…NOR_OP, including MULT_OP=4'd8), ALUOp codes, and a mult_state_t enum {IDLE, RUN, FIX, DONE}.
- Sub-module mult_shift_add_dp: accumulator, operand shift registers, adder and final negation. It is controlled by load/step/fix/commit strobes from the FSM in mult_sequencer.

## Test plan
- Unsigned 3 × 5, WIDTH=32: stall high from the start cycle, done exactly at cycle 34 after start; hi=0x00000000, lo=0x0000000F; done lasts one cycle.
- Signed −3 (0xFFFFFFFD) × 7: hi=0xFFFFFFFF, lo=0xFFFFFFEB. The same operands unsigned: hi=0x00000006, lo=0xFFFFFFEB.
- Extremes: unsigned 0xFFFFFFFF × 0xFFFFFFFF gives hi=0xFFFFFFFE, lo=0x00000001; signed 0x80000000 × 0x80000000 gives hi=0x40000000, lo=0x00000000.
- start pulsed during RUN: no restart, and exactly one done with the original operands' product. A second start in the cycle after DONE is accepted.
- flush at RUN cycle 10: IDLE next cycle, busy/stall low, no done, hi/lo unchanged from the previous result.
- arst_n asserted mid-RUN: all outputs zero immediately. After release, a new 2 × 2 start yields lo=4 at cycle 34.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, ALUOp codes and multiply sequencer states.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package alu_pkg;

   // ALU control codes driven by the ALU control decoder
   localparam logic [3:0] AND_OP  = 4'd0;
   localparam logic [3:0] OR_OP   = 4'd1;
   localparam logic [3:0] ADD_OP  = 4'd2;
   localparam logic [3:0] SUB_OP  = 4'd6;
   localparam logic [3:0] SLT_OP  = 4'd7;
   localparam logic [3:0] MULT_OP = 4'd8;
   localparam logic [3:0] NOR_OP  = 4'd12;

   // ALUOp codes from the main decoder
   localparam logic [1:0] ALUOP_MEM    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } mult_state_t;

endpackage

// File: rtl/mult_shift_add_dp.sv
// Radix-2 shift-add multiply datapath: magnitude load, accumulate, sign fix, HI/LO commit.
// Latency: one accumulate step per step strobe; HI/LO written on the commit edge.
// Backpressure: none; it acts only on strobes from the sequencer FSM.
module mult_shift_add_dp #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             load,
   input  logic             step,
   input  logic             fix,
   input  logic             commit,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             last,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;
   logic [CW-1:0]      cnt;
   logic               neg;

   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [2*WIDTH-1:0] acc_fixed;

   // Operand magnitudes; the most negative value maps onto itself read as unsigned
   always_comb begin
      a_neg     = signed_mode & operand_a[WIDTH-1];
      b_neg     = signed_mode & operand_b[WIDTH-1];
      mag_a     = a_neg ? -operand_a : operand_a;
      mag_b     = b_neg ? -operand_b : operand_b;
      acc_fixed = neg ? -acc : acc;
      last      = (cnt == CW'(WIDTH - 1));
   end

   // Working registers; the multiplicand is kept pre-shifted so no barrel shifter is needed
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
         neg    <= 1'b0;
      end else if (load) begin
         mcand  <= {{WIDTH{1'b0}}, mag_a};
         mplier <= mag_b;
         acc    <= '0;
         cnt    <= '0;
         neg    <= a_neg ^ b_neg;
      end else if (step) begin
         if (mplier[0]) begin
            acc <= acc + mcand;
         end
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + CW'(1);
      end else if (fix) begin
         acc <= acc_fixed;
      end
   end

   // Result registers; commit is issued together with fix so the signed value lands directly
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         hi <= '0;
         lo <= '0;
      end else if (commit) begin
         hi <= acc_fixed[2*WIDTH-1:WIDTH];
         lo <= acc_fixed[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/mult_sequencer.sv
// Multi-cycle multiply controller: accepts a start in IDLE, runs WIDTH shift-add steps, fixes sign, commits HI/LO.
// Latency: done and valid HI/LO WIDTH+2 cycles after the accepting edge; one multiply per WIDTH+3 cycles.
// Backpressure: stall holds the pipeline from the start cycle through FIX; start outside IDLE is dropped.
module mult_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             flush,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   mult_state_t state;
   mult_state_t state_nxt;
   logic        load;
   logic        step;
   logic        fix;
   logic        commit;
   logic        last;

   // State register
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and datapath strobes; flush aborts RUN/FIX without touching HI/LO
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      fix       = 1'b0;
      commit    = 1'b0;
      unique case (state)
         IDLE: begin
            if (start && !flush) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (flush) begin
               state_nxt = IDLE;
            end else begin
               step = 1'b1;
               if (last) begin
                  state_nxt = FIX;
               end
            end
         end
         FIX: begin
            if (flush) begin
               state_nxt = IDLE;
            end else begin
               fix       = 1'b1;
               commit    = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Status outputs; stall drops in DONE so EX advances and consumes HI/LO
   always_comb begin
      busy  = (state == RUN) || (state == FIX);
      done  = (state == DONE);
      stall = ((state == IDLE) && start && !flush) || busy;
   end

   mult_shift_add_dp #(
      .WIDTH (WIDTH)
   ) u_dp (
      .clk         (clk),
      .arst_n      (arst_n),
      .load        (load),
      .step        (step),
      .fix         (fix),
      .commit      (commit),
      .signed_mode (signed_mode),
      .operand_a   (operand_a),
      .operand_b   (operand_b),
      .last        (last),
      .hi          (hi),
      .lo          (lo)
   );

endmodule
